// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
//   Instruction-memory request/ready handshake between the fetch sequencer
//   and the instruction memory.
//
//   req   : request valid, held with a stable addr until ready is seen
//   addr  : request address (the current PC)
//   ready : memory completes the outstanding request this cycle
//
//   master modport : requester side (fetch_sequencer)
//   slave  modport : memory side
// ---------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic                     ready;

  modport master (
    output req,
    output addr,
    input  ready
  );

  modport slave (
    input  req,
    input  addr,
    output ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Controls the fetch-unit PC register (stall / load / load address), runs
//   the instruction-memory req/ready handshake, arbitrates redirect sources
//   (exception > branch > jump) and squashes wrong-path instructions.
//
// Ports
//   i_Clk, i_Reset_n  clock, asynchronous active-low reset
//   i_PC              current PC from the fetch unit
//   i_Pipe_Stall      downstream cannot accept an instruction this cycle
//   i_Exception       exception redirect request (pulse)
//   i_Branch_Taken    taken-branch redirect request (pulse), i_Branch_Target
//   i_Jump            jump redirect request (pulse), i_Jump_Target
//   imem              instruction-memory handshake (master side)
//   o_Stall           fetch unit: hold PC
//   o_Load            fetch unit: load o_Load_Address into PC
//   o_Load_Address    redirect target (zero when o_Load is low)
//   o_Instr_Valid     fetched word valid for decode this cycle
//   o_Flush           squash IF/ID contents
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       FLUSH_CYCLES  = 2,
  parameter logic [ADDRESS_WIDTH-1:0] EXC_VECTOR    = 'h00000080
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic [ADDRESS_WIDTH-1:0] i_PC,
  input  logic                     i_Pipe_Stall,
  input  logic                     i_Exception,
  input  logic                     i_Branch_Taken,
  input  logic [ADDRESS_WIDTH-1:0] i_Branch_Target,
  input  logic                     i_Jump,
  input  logic [ADDRESS_WIDTH-1:0] i_Jump_Target,
  fetch_sequencer_if.master        imem,
  output logic                     o_Stall,
  output logic                     o_Load,
  output logic [ADDRESS_WIDTH-1:0] o_Load_Address,
  output logic                     o_Instr_Valid,
  output logic                     o_Flush
);

  // Counter only needs to hold FLUSH_CYCLES; keep at least one bit so the
  // FLUSH_CYCLES=0 build still has a legal vector.
  localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_FLUSH    = 3'd4
  } state_t;

  state_t                   state_reg;
  logic [ADDRESS_WIDTH-1:0] pend_tgt_reg;
  logic                     pend_exc_reg;
  logic [CNT_W-1:0]         cnt_reg;

  // Registered outputs, decoded from the state being entered.
  logic                     req_reg;
  logic                     stall_reg;
  logic                     load_reg;
  logic [ADDRESS_WIDTH-1:0] load_addr_reg;
  logic                     flush_reg;

  // Redirect arbitration.
  logic                     redirect;
  logic                     win_exc;
  logic [ADDRESS_WIDTH-1:0] win_tgt;
  logic                     pend_exc_eff;
  logic                     pend_we;
  logic [ADDRESS_WIDTH-1:0] pend_tgt_next;
  logic                     pend_exc_next;
  logic                     fetch_ok;

  always_comb begin
    redirect = i_Exception | i_Branch_Taken | i_Jump;
    win_exc  = i_Exception;
    if (i_Exception) begin
      win_tgt = EXC_VECTOR;
    end else if (i_Branch_Taken) begin
      win_tgt = i_Branch_Target;
    end else begin
      win_tgt = i_Jump_Target;
    end

    // The pending target is consumed by the load issued in REDIRECT, so a
    // redirect arriving in that same cycle is never blocked by it.
    pend_exc_eff = (state_reg == ST_REDIRECT) ? 1'b0 : pend_exc_reg;

    // A non-exception must not displace a pending exception.
    pend_we       = redirect & ~(pend_exc_eff & ~win_exc);
    pend_tgt_next = pend_we ? win_tgt : pend_tgt_reg;
    pend_exc_next = pend_we ? win_exc : pend_exc_eff;

    fetch_ok = imem.ready & ~i_Pipe_Stall & ~redirect;
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_reg     <= ST_IDLE;
      pend_tgt_reg  <= '0;
      pend_exc_reg  <= 1'b0;
      cnt_reg       <= '0;
      req_reg       <= 1'b0;
      stall_reg     <= 1'b1;
      load_reg      <= 1'b0;
      load_addr_reg <= '0;
      flush_reg     <= 1'b0;
    end else begin
      load_reg      <= 1'b0;
      load_addr_reg <= '0;

      case (state_reg)
        ST_IDLE: begin
          // Redirects are ignored during the single idle cycle.
          state_reg <= ST_FETCH;
          req_reg   <= 1'b1;
          stall_reg <= 1'b1;
          flush_reg <= 1'b0;
        end

        ST_FETCH: begin
          if (redirect) begin
            pend_tgt_reg <= pend_tgt_next;
            pend_exc_reg <= pend_exc_next;
            if (imem.ready) begin
              state_reg     <= ST_REDIRECT;
              req_reg       <= 1'b0;
              stall_reg     <= 1'b0;
              load_reg      <= 1'b1;
              load_addr_reg <= pend_tgt_next;
              flush_reg     <= 1'b1;
            end else begin
              // Request is outstanding: hold req/addr until memory answers.
              state_reg <= ST_DRAIN;
              req_reg   <= 1'b1;
              stall_reg <= 1'b1;
              flush_reg <= 1'b0;
            end
          end
        end

        ST_DRAIN: begin
          pend_tgt_reg <= pend_tgt_next;
          pend_exc_reg <= pend_exc_next;
          if (imem.ready) begin
            // Drained word is discarded; go straight to the load.
            state_reg     <= ST_REDIRECT;
            req_reg       <= 1'b0;
            stall_reg     <= 1'b0;
            load_reg      <= 1'b1;
            load_addr_reg <= pend_tgt_next;
            flush_reg     <= 1'b1;
          end
        end

        ST_REDIRECT: begin
          if (redirect) begin
            // Reissue the load next cycle towards the newer target.
            pend_tgt_reg  <= pend_tgt_next;
            pend_exc_reg  <= pend_exc_next;
            req_reg       <= 1'b0;
            stall_reg     <= 1'b0;
            load_reg      <= 1'b1;
            load_addr_reg <= pend_tgt_next;
            flush_reg     <= 1'b1;
          end else begin
            pend_exc_reg <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state_reg <= ST_FETCH;
              req_reg   <= 1'b1;
              stall_reg <= 1'b1;
              flush_reg <= 1'b0;
            end else begin
              state_reg <= ST_FLUSH;
              cnt_reg   <= CNT_LOAD;
              req_reg   <= 1'b0;
              stall_reg <= 1'b1;
              flush_reg <= 1'b1;
            end
          end
        end

        ST_FLUSH: begin
          if (redirect) begin
            pend_tgt_reg  <= pend_tgt_next;
            pend_exc_reg  <= pend_exc_next;
            state_reg     <= ST_REDIRECT;
            req_reg       <= 1'b0;
            stall_reg     <= 1'b0;
            load_reg      <= 1'b1;
            load_addr_reg <= pend_tgt_next;
            flush_reg     <= 1'b1;
          end else if (cnt_reg <= CNT_ONE) begin
            state_reg <= ST_FETCH;
            req_reg   <= 1'b1;
            stall_reg <= 1'b1;
            flush_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          req_reg   <= 1'b0;
          stall_reg <= 1'b1;
          flush_reg <= 1'b0;
        end
      endcase
    end
  end

  // In FETCH the stall/valid decision depends on this cycle's ready, stall
  // and redirect inputs, so those two outputs bypass the registers there.
  assign o_Stall        = (state_reg == ST_FETCH) ? ~fetch_ok : stall_reg;
  assign o_Instr_Valid  = (state_reg == ST_FETCH) & fetch_ok;
  assign o_Load         = load_reg;
  assign o_Load_Address = load_addr_reg;
  assign o_Flush        = flush_reg;
  assign imem.req       = req_reg;
  assign imem.addr      = i_PC;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Drives fetch_sequencer with directed scenarios followed by randomized
//   traffic, and compares every output every cycle against a behavioural
//   model of the sequencing rules (flags + counters, PC tracked as a number).
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;
  localparam int          AW  = 32;
  localparam int          FC  = 2;
  localparam logic [31:0] EXC = 32'h00000080;

  logic          i_Clk = 1'b0;
  logic          i_Reset_n = 1'b0;
  logic [AW-1:0] i_PC;
  logic          i_Pipe_Stall = 1'b0;
  logic          i_Exception = 1'b0;
  logic          i_Branch_Taken = 1'b0;
  logic [AW-1:0] i_Branch_Target = '0;
  logic          i_Jump = 1'b0;
  logic [AW-1:0] i_Jump_Target = '0;
  logic          o_Stall;
  logic          o_Load;
  logic [AW-1:0] o_Load_Address;
  logic          o_Instr_Valid;
  logic          o_Flush;

  fetch_sequencer_if #(.ADDRESS_WIDTH(AW)) imem ();

  fetch_sequencer #(
    .ADDRESS_WIDTH(AW),
    .FLUSH_CYCLES (FC),
    .EXC_VECTOR   (EXC)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Reset_n      (i_Reset_n),
    .i_PC           (i_PC),
    .i_Pipe_Stall   (i_Pipe_Stall),
    .i_Exception    (i_Exception),
    .i_Branch_Taken (i_Branch_Taken),
    .i_Branch_Target(i_Branch_Target),
    .i_Jump         (i_Jump),
    .i_Jump_Target  (i_Jump_Target),
    .imem           (imem),
    .o_Stall        (o_Stall),
    .o_Load         (o_Load),
    .o_Load_Address (o_Load_Address),
    .o_Instr_Valid  (o_Instr_Valid),
    .o_Flush        (o_Flush)
  );

  always #5 i_Clk = ~i_Clk;

  // Fetch-unit PC register driven by the DUT's stall/load.
  logic [AW-1:0] pc_reg;
  always @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n)   pc_reg <= '0;
    else if (o_Load)  pc_reg <= o_Load_Address;
    else if (!o_Stall) pc_reg <= pc_reg + 1;
  end
  assign i_PC = pc_reg;

  initial imem.ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  bit          m_started;
  bit          m_drain;
  bit          m_load_due;
  int          m_flush_left;
  logic [31:0] m_pend_tgt;
  bit          m_pend_exc;
  logic [31:0] m_pc;

  function automatic void model_reset();
    m_started    = 0;
    m_drain      = 0;
    m_load_due   = 0;
    m_flush_left = 0;
    m_pend_tgt   = '0;
    m_pend_exc   = 0;
    m_pc         = '0;
  endfunction

  // Entered and left at posedge+1. Applies inputs, checks outputs mid-cycle,
  // advances the model, then steps to the next cycle.
  task automatic cycle(input bit rdy, input bit ps, input bit exc, input bit br,
                       input logic [31:0] bt, input bit jp, input logic [31:0] jt);
    bit          redir;
    bit          wexc;
    logic [31:0] wtgt;
    bit e_req, e_stall, e_load, e_flush, e_valid;

    imem.ready      = rdy;
    i_Pipe_Stall    = ps;
    i_Exception     = exc;
    i_Branch_Taken  = br;
    i_Branch_Target = bt;
    i_Jump          = jp;
    i_Jump_Target   = jt;
    #4;

    redir = exc | br | jp;
    wexc  = exc;
    wtgt  = exc ? EXC : (br ? bt : jt);

    e_req = 0; e_stall = 1; e_load = 0; e_flush = 0; e_valid = 0;
    if (!m_started) begin
    end else if (m_load_due) begin
      e_load = 1; e_stall = 0; e_flush = 1;
    end else if (m_flush_left > 0) begin
      e_flush = 1;
    end else if (m_drain) begin
      e_req = 1;
    end else begin
      e_req   = 1;
      e_valid = rdy & !ps & !redir;
      e_stall = !e_valid;
    end

    check("req",   {31'd0, imem.req},      {31'd0, e_req});
    check("stall", {31'd0, o_Stall},       {31'd0, e_stall});
    check("load",  {31'd0, o_Load},        {31'd0, e_load});
    check("flush", {31'd0, o_Flush},       {31'd0, e_flush});
    check("valid", {31'd0, o_Instr_Valid}, {31'd0, e_valid});
    if (e_req)  check("addr",      imem.addr,      m_pc);
    if (e_load) check("load_addr", o_Load_Address, m_pend_tgt);

    if (e_load)        m_pc = m_pend_tgt;
    else if (!e_stall) m_pc = m_pc + 1;

    if (!m_started) begin
      m_started = 1;
    end else if (m_load_due) begin
      if (redir) begin
        m_pend_tgt = wtgt; m_pend_exc = wexc;
      end else begin
        m_load_due = 0; m_pend_exc = 0; m_flush_left = FC;
      end
    end else if (m_flush_left > 0) begin
      if (redir) begin
        m_pend_tgt = wtgt; m_pend_exc = wexc;
        m_load_due = 1; m_flush_left = 0;
      end else begin
        m_flush_left--;
      end
    end else if (m_drain) begin
      if (redir && (wexc || !m_pend_exc)) begin
        m_pend_tgt = wtgt; m_pend_exc = wexc;
      end
      if (rdy) begin
        m_drain = 0; m_load_due = 1;
      end
    end else if (redir) begin
      m_pend_tgt = wtgt; m_pend_exc = wexc;
      if (rdy) m_load_due = 1;
      else     m_drain = 1;
    end

    @(posedge i_Clk);
    #1;
  endtask

  task automatic idle_cycle(input bit rdy);
    cycle(rdy, 0, 0, 0, '0, 0, '0);
  endtask

  // Entered at posedge+1: asserts reset mid-cycle and checks the outputs
  // drop immediately, then releases after the next edge (IDLE cycle follows).
  task automatic do_reset();
    i_Reset_n = 1'b0;
    #1;
    check("rst_req",   {31'd0, imem.req},      32'd0);
    check("rst_stall", {31'd0, o_Stall},       32'd1);
    check("rst_load",  {31'd0, o_Load},        32'd0);
    check("rst_flush", {31'd0, o_Flush},       32'd0);
    check("rst_valid", {31'd0, o_Instr_Valid}, 32'd0);
    @(posedge i_Clk);
    #1;
    i_Reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge i_Clk);
    #1;
    do_reset();

    // Free-running fetch: IDLE then PC 0,1,2,...
    for (int i = 0; i < 6; i++) idle_cycle(1);

    // Ready low for three cycles, then one completion.
    for (int i = 0; i < 3; i++) idle_cycle(0);
    idle_cycle(1);

    // Branch and jump together: branch wins; flush 1+FC cycles.
    cycle(1, 0, 0, 1, 32'h40, 1, 32'h80);
    for (int i = 0; i < 5; i++) idle_cycle(1);

    // Exception while draining, then a branch before ready: exception kept.
    cycle(0, 0, 0, 0, '0, 1, 32'h100);
    cycle(0, 0, 1, 0, '0, 0, '0);
    cycle(0, 0, 0, 1, 32'h20, 0, '0);
    idle_cycle(1);
    for (int i = 0; i < 5; i++) idle_cycle(1);

    // Jump during FLUSH: reissued redirect and a fresh flush count.
    cycle(1, 0, 0, 1, 32'h200, 0, '0);
    idle_cycle(1);
    cycle(1, 0, 0, 0, '0, 1, 32'h300);
    for (int i = 0; i < 6; i++) idle_cycle(1);

    // Redirect during the REDIRECT cycle itself.
    cycle(1, 0, 0, 0, '0, 1, 32'h400);
    cycle(1, 0, 0, 1, 32'h500, 0, '0);
    for (int i = 0; i < 5; i++) idle_cycle(1);

    // Reset while draining.
    cycle(0, 0, 0, 1, 32'h600, 0, '0);
    idle_cycle(0);
    do_reset();
    for (int i = 0; i < 4; i++) idle_cycle(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 2,
              $urandom_range(0, 29) == 0,
              $urandom_range(0, 14) == 0, {$urandom_range(0, 255), 4'h0},
              $urandom_range(0, 14) == 0, {$urandom_range(0, 255), 4'h8});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a hung simulation.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
